// File: rtl/ysyx_040750_rr_arb_mux.sv
// Registered M-channel arbitrating selector: a round-robin or fixed-priority arbiter picks one
// valid input, and that word is loaded into a one-entry output register with a valid/ready handshake.
module ysyx_040750_rr_arb_mux #(
   parameter int N  = 64,
   parameter int M  = 4,
   parameter int RR = 1
) (
   input  logic           I_sys_clk,
   input  logic           I_rst,
   input  logic           I_flush,
   input  logic [M-1:0]   I_req_valid,
   input  logic [N*M-1:0] I_req_data,
   output logic [M-1:0]   O_req_ready,
   output logic           O_valid,
   output logic [N-1:0]   O_data,
   output logic [M-1:0]   O_grant,
   input  logic           I_ready
);

   localparam int            PW       = (M > 1) ? $clog2(M) : 1;
   localparam logic [PW-1:0] LAST_RST = PW'(M - 1);

   logic          r_valid;
   logic [N-1:0]  r_data;
   logic [M-1:0]  r_grant;
   logic [PW-1:0] r_last;

   logic          w_can_load;
   logic          w_xfer;
   logic [M-1:0]  w_mask;
   logic [M-1:0]  w_req_hi;
   logic [M-1:0]  w_gnt;
   logic [PW-1:0] w_gnt_idx;
   logic [N-1:0]  w_sel_data;

   // Isolate the lowest set bit (two's complement trick).
   function automatic logic [M-1:0] f_lowest(input logic [M-1:0] v);
      return v & (~v + M'(1));
   endfunction

   assign w_can_load = !r_valid || I_ready;

   // Channels strictly above the pointer get first pick; otherwise wrap to the lowest requester.
   always_comb begin
      // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
      w_mask = '0;
      for (int i = 0; i < M; i++) begin
         w_mask[i] = (PW'(i) > r_last);
      end
   end

   assign w_req_hi = I_req_valid & w_mask;

   always_comb begin
      w_gnt = '0;
      if (RR != 0) begin
         w_gnt = (|w_req_hi) ? f_lowest(w_req_hi) : f_lowest(I_req_valid);
      end else begin
         w_gnt = f_lowest(I_req_valid);
      end
   end

   // AND-OR select and index encode, both driven directly by the one-hot grant.
   always_comb begin
      w_sel_data = '0;
      w_gnt_idx  = '0;
      for (int i = 0; i < M; i++) begin
         w_sel_data = w_sel_data | ({N{w_gnt[i]}} & I_req_data[i*N +: N]);
         if (w_gnt[i]) begin
            w_gnt_idx = w_gnt_idx | PW'(i);
         end
      end
   end

   assign O_req_ready = (w_can_load && !I_flush && !I_rst) ? w_gnt : '0;
   assign w_xfer      = |O_req_ready;

   always_ff @(posedge I_sys_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (I_rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_grant <= '0;
         r_last  <= LAST_RST;
      end else if (I_flush) begin
         r_valid <= 1'b0;
         r_grant <= '0;
      end else if (w_can_load) begin
         if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_grant <= w_gnt;
            if (RR != 0) begin
               r_last <= w_gnt_idx;
            end
         end else begin
            r_valid <= 1'b0;
            r_grant <= '0;
         end
      end
   end

   assign O_valid = r_valid;
   assign O_data  = r_data;
   assign O_grant = r_grant;

   a_ready_onehot : assert property (@(posedge I_sys_clk) $onehot0(O_req_ready));
   a_grant_valid  : assert property (@(posedge I_sys_clk) disable iff (I_rst)
                                     (O_valid ? $onehot(O_grant) : (O_grant == '0)));

endmodule

// File: tb/tb_ysyx_040750_rr_arb_mux.sv
// Directed bench: a round-robin and a fixed-priority instance driven by the same
// inputs, each scenario checked against hand-derived expectations.
module tb_ysyx_040750_rr_arb_mux;

   localparam int N = 64;
   localparam int M = 4;

   logic           clk;
   logic           rst;
   logic           flush;
   logic [M-1:0]   valid;
   logic [N*M-1:0] data;
   logic           rdy;

   logic [M-1:0]   rr_req_ready, fp_req_ready;
   logic           rr_valid, fp_valid;
   logic [N-1:0]   rr_data, fp_data;
   logic [M-1:0]   rr_grant, fp_grant;

   int checks   = 0;
   int failures = 0;

   ysyx_040750_rr_arb_mux #(.N(N), .M(M), .RR(1)) dut_rr (
      .I_sys_clk(clk), .I_rst(rst), .I_flush(flush),
      .I_req_valid(valid), .I_req_data(data), .O_req_ready(rr_req_ready),
      .O_valid(rr_valid), .O_data(rr_data), .O_grant(rr_grant), .I_ready(rdy)
   );

   ysyx_040750_rr_arb_mux #(.N(N), .M(M), .RR(0)) dut_fp (
      .I_sys_clk(clk), .I_rst(rst), .I_flush(flush),
      .I_req_valid(valid), .I_req_data(data), .O_req_ready(fp_req_ready),
      .O_valid(fp_valid), .O_data(fp_data), .O_grant(fp_grant), .I_ready(rdy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Drive inputs 1 time unit after an edge, then let combinational paths settle.
   task automatic drive(input logic [M-1:0] v, input logic r, input logic f, input logic rs);
      valid = v; rdy = r; flush = f; rst = rs;
      #1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      drive(4'b0000, 1'b1, 1'b0, 1'b1);
      next_cycle();
   endtask

   task automatic test_reset();
      drive(4'b1111, 1'b1, 1'b0, 1'b1);
      checks++;
      if (rr_req_ready !== 4'b0000) begin
         failures++; $display("FAIL reset_ready got=%b exp=0000", rr_req_ready);
      end
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         drive(4'b0000, 1'b1, 1'b0, 1'b0);
         checks++;
         if ({rr_valid, rr_grant, rr_data, rr_req_ready} !== {1'b0, 4'b0000, 64'h0, 4'b0000}) begin
            failures++;
            $display("FAIL idle cyc=%0d got v=%b g=%b d=%h r=%b exp all zero",
                     c, rr_valid, rr_grant, rr_data, rr_req_ready);
         end
         next_cycle();
      end
   endtask

   task automatic test_rr_all();
      logic [M-1:0] exp_r, exp_g;
      logic [N-1:0] exp_d;
      apply_reset();
      for (int c = 0; c < 8; c++) begin
         drive(4'b1111, 1'b1, 1'b0, 1'b0);
         exp_r = 4'b0001 << (c % 4);
         checks++;
         if (rr_req_ready !== exp_r) begin
            failures++; $display("FAIL rr_all_ready cyc=%0d got=%b exp=%b", c, rr_req_ready, exp_r);
         end
         if (c >= 1) begin
            exp_g = 4'b0001 << ((c - 1) % 4);
            exp_d = 64'h1000 + 64'((c - 1) % 4);
            checks++;
            if ({rr_valid, rr_grant, rr_data} !== {1'b1, exp_g, exp_d}) begin
               failures++;
               $display("FAIL rr_all_out cyc=%0d got v=%b g=%b d=%h exp v=1 g=%b d=%h",
                        c, rr_valid, rr_grant, rr_data, exp_g, exp_d);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_rr_pair();
      logic [M-1:0] exp_r, exp_g;
      apply_reset();
      for (int c = 0; c < 4; c++) begin
         drive(4'b1010, 1'b1, 1'b0, 1'b0);
         exp_r = (c % 2 == 0) ? 4'b0010 : 4'b1000;
         checks++;
         if (rr_req_ready !== exp_r) begin
            failures++; $display("FAIL rr_pair_ready cyc=%0d got=%b exp=%b", c, rr_req_ready, exp_r);
         end
         if (c >= 1) begin
            exp_g = (c % 2 == 1) ? 4'b0010 : 4'b1000;
            checks++;
            if ({rr_valid, rr_grant} !== {1'b1, exp_g}) begin
               failures++;
               $display("FAIL rr_pair_out cyc=%0d got v=%b g=%b exp v=1 g=%b", c, rr_valid, rr_grant, exp_g);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      data[2*N +: N] = 64'hAA;
      drive(4'b0100, 1'b1, 1'b0, 1'b0);
      checks++;
      if (rr_req_ready !== 4'b0100) begin
         failures++; $display("FAIL bp_load_ready got=%b exp=0100", rr_req_ready);
      end
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         drive(4'b0001, 1'b0, 1'b0, 1'b0);
         checks++;
         if ({rr_valid, rr_grant, rr_data, rr_req_ready} !== {1'b1, 4'b0100, 64'hAA, 4'b0000}) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got v=%b g=%b d=%h r=%b exp v=1 g=0100 d=aa r=0000",
                     c, rr_valid, rr_grant, rr_data, rr_req_ready);
         end
         next_cycle();
      end
      drive(4'b0001, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({rr_valid, rr_data, rr_req_ready} !== {1'b1, 64'hAA, 4'b0001}) begin
         failures++;
         $display("FAIL bp_release got v=%b d=%h r=%b exp v=1 d=aa r=0001", rr_valid, rr_data, rr_req_ready);
      end
      next_cycle();
      drive(4'b0000, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({rr_valid, rr_grant, rr_data} !== {1'b1, 4'b0001, 64'h1000}) begin
         failures++;
         $display("FAIL bp_after got v=%b g=%b d=%h exp v=1 g=0001 d=1000", rr_valid, rr_grant, rr_data);
      end
      data[2*N +: N] = 64'h1002;
      next_cycle();
   endtask

   task automatic test_fixed();
      apply_reset();
      for (int c = 0; c < 4; c++) begin
         drive(4'b1001, 1'b1, 1'b0, 1'b0);
         checks++;
         if (fp_req_ready !== 4'b0001) begin
            failures++; $display("FAIL fp_ready cyc=%0d got=%b exp=0001", c, fp_req_ready);
         end
         if (c >= 1) begin
            checks++;
            if ({fp_valid, fp_grant, fp_data} !== {1'b1, 4'b0001, 64'h1000}) begin
               failures++;
               $display("FAIL fp_out cyc=%0d got v=%b g=%b d=%h exp v=1 g=0001 d=1000",
                        c, fp_valid, fp_grant, fp_data);
            end
         end
         next_cycle();
      end
      drive(4'b1000, 1'b1, 1'b0, 1'b0);
      checks++;
      if (fp_req_ready !== 4'b1000) begin
         failures++; $display("FAIL fp_drop0_ready got=%b exp=1000", fp_req_ready);
      end
      next_cycle();
      drive(4'b0000, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({fp_valid, fp_grant, fp_data} !== {1'b1, 4'b1000, 64'h1003}) begin
         failures++;
         $display("FAIL fp_drop0_out got v=%b g=%b d=%h exp v=1 g=1000 d=1003", fp_valid, fp_grant, fp_data);
      end
      next_cycle();
   endtask

   task automatic test_flush_and_reset();
      apply_reset();
      drive(4'b0010, 1'b1, 1'b0, 1'b0);
      next_cycle();
      drive(4'b0001, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({rr_valid, rr_grant, rr_req_ready} !== {1'b1, 4'b0010, 4'b0000}) begin
         failures++;
         $display("FAIL flush_pre got v=%b g=%b r=%b exp v=1 g=0010 r=0000", rr_valid, rr_grant, rr_req_ready);
      end
      next_cycle();
      drive(4'b1111, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({rr_valid, rr_grant, rr_data, rr_req_ready} !== {1'b0, 4'b0000, 64'h1001, 4'b0100}) begin
         failures++;
         $display("FAIL flush_post got v=%b g=%b d=%h r=%b exp v=0 g=0000 d=1001 r=0100",
                  rr_valid, rr_grant, rr_data, rr_req_ready);
      end
      next_cycle();
      drive(4'b1111, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({rr_valid, rr_grant, rr_data, rr_req_ready} !== {1'b1, 4'b0100, 64'h1002, 4'b0000}) begin
         failures++;
         $display("FAIL flush_next got v=%b g=%b d=%h r=%b exp v=1 g=0100 d=1002 r=0000",
                  rr_valid, rr_grant, rr_data, rr_req_ready);
      end
      next_cycle();
      drive(4'b1111, 1'b0, 1'b0, 1'b1);
      checks++;
      if (rr_req_ready !== 4'b0000) begin
         failures++; $display("FAIL midrst_ready got=%b exp=0000", rr_req_ready);
      end
      next_cycle();
      drive(4'b1111, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({rr_valid, rr_grant, rr_data, rr_req_ready} !== {1'b0, 4'b0000, 64'h0, 4'b0001}) begin
         failures++;
         $display("FAIL midrst_post got v=%b g=%b d=%h r=%b exp v=0 g=0000 d=0 r=0001",
                  rr_valid, rr_grant, rr_data, rr_req_ready);
      end
      next_cycle();
      drive(4'b0000, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({rr_valid, rr_grant, rr_data} !== {1'b1, 4'b0001, 64'h1000}) begin
         failures++;
         $display("FAIL midrst_grant got v=%b g=%b d=%h exp v=1 g=0001 d=1000", rr_valid, rr_grant, rr_data);
      end
      next_cycle();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; valid = '0; rdy = 1'b1;
      for (int i = 0; i < M; i++) begin
         data[i*N +: N] = 64'h1000 + 64'(i);
      end
      next_cycle();
      test_reset();
      test_rr_all();
      test_rr_pair();
      test_backpressure();
      test_fixed();
      test_flush_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
